// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Small FIFO between the fetch stage and decode. Each entry holds the PC and
//   the instruction word fetched at that PC. Misaligned PCs are refused and
//   latched in a sticky MISALIGN flag. FLUSH empties the queue on a redirect.
//
//   Handshake: a transfer happens on a rising edge when valid and ready are
//   both 1 and FLUSH is 0. PUSH_ready depends only on COUNT. A pop in the same
//   cycle does not raise it, so a full queue never passes a push through.
//
//   Parameters
//     DEPTH : number of entries (power of two, >= 2)
//     WIDTH : width of PC and instruction words
//
//   Ports
//     CLK, RESET                  clock, asynchronous active-low reset
//     PUSH_valid/ready/pc/instr   enqueue side (from fetch)
//     POP_valid/ready/pc/instr    dequeue side (to decode); zeros when empty
//     FLUSH                       discard all entries, priority over push/pop
//     COUNT                       number of valid entries
//     MISALIGN                    sticky: misaligned push was offered
//
//   Optional build macro
//     FETCH_QUEUE_BYPASS_EN : when the queue is empty, an offered aligned push
//       is shown on POP_* in the same cycle. If decode takes it that cycle,
//       the entry is not stored.
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       PUSH_valid,
  output logic                       PUSH_ready,
  input  logic [WIDTH-1:0]           PUSH_pc,
  input  logic [WIDTH-1:0]           PUSH_instr,
  output logic                       POP_valid,
  input  logic                       POP_ready,
  output logic [WIDTH-1:0]           POP_pc,
  output logic [WIDTH-1:0]           POP_instr,
  input  logic                       FLUSH,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       MISALIGN
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = AW'(0) + (AW+1)'(DEPTH);

  logic [WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [WIDTH-1:0] instr_mem_q [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          misalign_q, misalign_d;

  logic aligned;
  logic empty;
  logic push_ok;
  logic pop_ok;
  logic bypass_take;
  logic write_en;

  assign aligned = (PUSH_pc[1:0] == 2'b00);
  assign empty   = (count_q == '0);

  assign PUSH_ready = (count_q < DEPTH_C);
  assign COUNT      = count_q;
  assign MISALIGN   = misalign_q;

  assign push_ok = PUSH_valid && PUSH_ready && !FLUSH && aligned;
  // A stored-entry pop; the empty-queue bypass is handled separately.
  assign pop_ok  = !empty && POP_ready && !FLUSH;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Entry handed straight to decode from an empty queue is never written.
  assign bypass_take = push_ok && empty && POP_ready;
`else
  assign bypass_take = 1'b0;
`endif

  assign write_en = push_ok && !bypass_take;

  // Head-of-queue view; zeros while empty so stale storage is never visible.
  always_comb begin
    POP_valid = !empty;
    POP_pc    = empty ? '0 : pc_mem_q[head_q];
    POP_instr = empty ? '0 : instr_mem_q[head_q];
`ifdef FETCH_QUEUE_BYPASS_EN
    if (empty && PUSH_valid && aligned) begin
      POP_valid = 1'b1;
      POP_pc    = PUSH_pc;
      POP_instr = PUSH_instr;
    end
`endif
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    misalign_d = misalign_q;
    if (FLUSH) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      misalign_d = 1'b0;
    end else begin
      // Pointer width equals log2(DEPTH), so increments wrap naturally.
      if (pop_ok)   head_d = head_q + 1'b1;
      if (write_en) tail_d = tail_q + 1'b1;
      case ({write_en, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    // A misaligned offer sets the flag even in a flush cycle.
    if (PUSH_valid && !aligned) misalign_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // Storage is not reset; empty-gating on POP_* hides its contents.
  always_ff @(posedge CLK) begin
    if (RESET && write_en) begin
      pc_mem_q[tail_q]    <= PUSH_pc;
      instr_mem_q[tail_q] <= PUSH_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//   Directed, table-driven bench for fetch_queue (DEPTH=4, WIDTH=32).
//   Each row gives the inputs for one cycle and the outputs expected before
//   the next rising edge. Instruction words are the bitwise inverse of the PC.
//   Reset behaviour is covered by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             CLK;
  logic             RESET;
  logic             PUSH_valid;
  logic             PUSH_ready;
  logic [WIDTH-1:0] PUSH_pc;
  logic [WIDTH-1:0] PUSH_instr;
  logic             POP_valid;
  logic             POP_ready;
  logic [WIDTH-1:0] POP_pc;
  logic [WIDTH-1:0] POP_instr;
  logic             FLUSH;
  logic [2:0]       COUNT;
  logic             MISALIGN;

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .RESET(RESET),
    .PUSH_valid(PUSH_valid), .PUSH_ready(PUSH_ready),
    .PUSH_pc(PUSH_pc), .PUSH_instr(PUSH_instr),
    .POP_valid(POP_valid), .POP_ready(POP_ready),
    .POP_pc(POP_pc), .POP_instr(POP_instr),
    .FLUSH(FLUSH), .COUNT(COUNT), .MISALIGN(MISALIGN)
  );

  // clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        pv;
    logic [31:0] pc;
    logic        pr;
    logic        fl;
    logic        e_rdy;
    logic        e_val;
    logic [31:0] e_pc;
    logic [2:0]  e_cnt;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];
  int   n_tests;
  int   n_fail;

  task automatic add(input string name, input logic pv, input logic [31:0] pc,
                     input logic pr, input logic fl, input logic e_rdy,
                     input logic e_val, input logic [31:0] e_pc,
                     input logic [2:0] e_cnt, input logic e_mis);
    vec_t v;
    v.name = name; v.pv = pv; v.pc = pc; v.pr = pr; v.fl = fl;
    v.e_rdy = e_rdy; v.e_val = e_val; v.e_pc = e_pc; v.e_cnt = e_cnt;
    v.e_mis = e_mis;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // compare all outputs against an expected state
  task automatic check_all(input string name, input logic e_rdy,
                           input logic e_val, input logic [31:0] e_pc,
                           input logic [2:0] e_cnt, input logic e_mis);
    logic [31:0] e_instr;
    e_instr = e_val ? ~e_pc : 32'h0;
    check({name, ".push_ready"}, {31'b0, PUSH_ready}, {31'b0, e_rdy});
    check({name, ".pop_valid"},  {31'b0, POP_valid},  {31'b0, e_val});
    check({name, ".pop_pc"},     POP_pc,              e_pc);
    check({name, ".pop_instr"},  POP_instr,           e_instr);
    check({name, ".count"},      {29'b0, COUNT},      {29'b0, e_cnt});
    check({name, ".misalign"},   {31'b0, MISALIGN},   {31'b0, e_mis});
  endtask

  // driver: inputs for one cycle, check before the edge, then advance
  task automatic drive(input logic pv, input logic [31:0] pc,
                       input logic pr, input logic fl);
    PUSH_valid = pv;
    PUSH_pc    = pc;
    PUSH_instr = ~pc;
    POP_ready  = pr;
    FLUSH      = fl;
  endtask

  task automatic idle_edge();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // ---------------- vector table ----------------
    // fill to full, fifth push refused
    add("fill0", 1, 32'h0,  0, 0, 1, 0, 32'h0, 0, 0);
    add("fill1", 1, 32'h4,  0, 0, 1, 1, 32'h0, 1, 0);
    add("fill2", 1, 32'h8,  0, 0, 1, 1, 32'h0, 2, 0);
    add("fill3", 1, 32'hC,  0, 0, 1, 1, 32'h0, 3, 0);
    add("full5", 1, 32'h10, 0, 0, 0, 1, 32'h0, 4, 0);
    // drain in order
    add("drain0", 0, 32'h0, 1, 0, 0, 1, 32'h0, 4, 0);
    add("drain1", 0, 32'h0, 1, 0, 1, 1, 32'h4, 3, 0);
    add("drain2", 0, 32'h0, 1, 0, 1, 1, 32'h8, 2, 0);
    add("drain3", 0, 32'h0, 1, 0, 1, 1, 32'hC, 1, 0);
    add("empty",  0, 32'h0, 0, 0, 1, 0, 32'h0, 0, 0);
    // streaming at COUNT=2, ten entries, tail wraps twice
    for (int i = 0; i < 10; i++) begin
      logic [31:0] head_pc;
      head_pc = (i >= 2) ? 32'(4 * (i - 2)) : 32'h0;
      add($sformatf("stream%0d", i), 1, 32'(4 * i), (i >= 2), 0,
          1, (i >= 1), (i >= 1) ? head_pc : 32'h0, 3'((i > 2) ? 2 : i), 0);
    end
    add("stream_d0", 0, 32'h0, 1, 0, 1, 1, 32'h20, 2, 0);
    add("stream_d1", 0, 32'h0, 1, 0, 1, 1, 32'h24, 1, 0);
    add("stream_e",  0, 32'h0, 0, 0, 1, 0, 32'h0,  0, 0);
    // flush with simultaneous push and pop
    add("fl_p0", 1, 32'h50, 0, 0, 1, 0, 32'h0,  0, 0);
    add("fl_p1", 1, 32'h54, 0, 0, 1, 1, 32'h50, 1, 0);
    add("fl_p2", 1, 32'h58, 0, 0, 1, 1, 32'h50, 2, 0);
    add("flush", 1, 32'h40, 1, 1, 1, 1, 32'h50, 3, 0);
    add("fl_e",  0, 32'h0,  0, 0, 1, 0, 32'h0,  0, 0);
    add("fl_p3", 1, 32'h60, 0, 0, 1, 0, 32'h0,  0, 0);
    add("fl_h",  0, 32'h0,  1, 0, 1, 1, 32'h60, 1, 0);
    add("fl_e2", 0, 32'h0,  0, 0, 1, 0, 32'h0,  0, 0);
    // misaligned push, sticky flag, flush clearing rules
    add("mis_push",  1, 32'h6,  0, 0, 1, 0, 32'h0,  0, 0);
    add("mis_hold",  0, 32'h0,  0, 0, 1, 0, 32'h0,  0, 1);
    add("mis_ok",    1, 32'h70, 0, 0, 1, 0, 32'h0,  0, 1);
    add("mis_h2",    0, 32'h0,  0, 0, 1, 1, 32'h70, 1, 1);
    add("mis_flmis", 1, 32'hA,  0, 1, 1, 1, 32'h70, 1, 1);
    add("mis_kept",  0, 32'h0,  0, 1, 1, 0, 32'h0,  0, 1);
    add("mis_clr",   0, 32'h0,  0, 0, 1, 0, 32'h0,  0, 0);
    // push into an empty queue with decode ready
`ifdef FETCH_QUEUE_BYPASS_EN
    add("byp_push", 1, 32'h100, 1, 0, 1, 1, 32'h100, 0, 0);
    add("byp_after", 0, 32'h0,  0, 0, 1, 0, 32'h0,   0, 0);
`else
    add("byp_push", 1, 32'h100, 1, 0, 1, 0, 32'h0,   0, 0);
    add("byp_after", 0, 32'h0,  1, 0, 1, 1, 32'h100, 1, 0);
`endif
    add("byp_e", 0, 32'h0, 0, 0, 1, 0, 32'h0, 0, 0);

    // ---------------- reset sequence ----------------
    RESET = 1'b0;
    drive(1'b1, 32'h0, 1'b1, 1'b0);   // push offered during reset edge
    #2;
    check_all("reset", 1, 0, 32'h0, 0, 0);
    @(posedge CLK);
    #1;
    check_all("reset_edge", 1, 0, 32'h0, 0, 0);
    RESET = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_all("reset_rel", 1, 0, 32'h0, 0, 0);
    @(posedge CLK);
    #1;

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      drive(vecs[i].pv, vecs[i].pc, vecs[i].pr, vecs[i].fl);
      #1;
      check_all(vecs[i].name, vecs[i].e_rdy, vecs[i].e_val, vecs[i].e_pc,
                vecs[i].e_cnt, vecs[i].e_mis);
      @(posedge CLK);
      #1;
    end

    // ---------------- mid-operation reset ----------------
    drive(1'b1, 32'h200, 1'b0, 1'b0);
    @(posedge CLK); #1;
    drive(1'b1, 32'h204, 1'b0, 1'b0);
    @(posedge CLK); #1;
    drive(1'b1, 32'h7, 1'b0, 1'b0);   // also set MISALIGN before reset
    @(posedge CLK); #1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_all("pre_rst", 1, 1, 32'h200, 2, 1);
    #1;
    RESET = 1'b0;                      // between edges: async clear
    #1;
    check_all("mid_rst", 1, 0, 32'h0, 0, 0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    drive(1'b1, 32'h300, 1'b0, 1'b0);
    @(posedge CLK); #1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_all("post_rst", 1, 1, 32'h300, 1, 0);
    idle_edge();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter WIDTH, default 32, bit width of stored PC and instruction words.
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 PUSH_valid  input  1  fetch stage offers {PUSH_pc, PUSH_instr} this cycle.
REQ-006 PUSH_ready  output  1  queue accepts a push this cycle.
REQ-007 PUSH_pc  input  WIDTH  PC of offered instruction (PC register output).
REQ-008 PUSH_instr  input  WIDTH  instruction word fetched at PUSH_pc.
REQ-009 POP_valid  output  1  head entry available to decode.
REQ-010 POP_ready  input  1  decode consumes head this cycle.
REQ-011 POP_pc  output  WIDTH  PC of head entry.
REQ-012 POP_instr  output  WIDTH  instruction of head entry.
REQ-013 FLUSH  input  1  discard all entries (taken branch/jump redirect).
REQ-014 COUNT  output  log2(DEPTH)+1  number of valid entries.
REQ-015 MISALIGN  output  1  sticky flag: a push with PUSH_pc[1:0] != 2'b00 was offered.

Function
REQ-016 Push accepted iff PUSH_valid && PUSH_ready && FLUSH==0 && PUSH_pc[1:0]==0; entry written at tail, tail increments modulo DEPTH.
REQ-017 PUSH_ready SHALL be 1 iff COUNT < DEPTH; a pop in the same cycle SHALL NOT raise PUSH_ready (no full-pass-through).
REQ-018 Pop occurs iff POP_valid && POP_ready && FLUSH==0; head increments modulo DEPTH.
REQ-019 POP_valid SHALL be 1 iff COUNT > 0 (bypass case: REQ-031); POP_pc/POP_instr SHALL show the head entry, and 0 when empty.
REQ-020 Latency: entry pushed at edge n is visible on POP_* immediately after edge n.
REQ-021 Simultaneous accepted push and pop SHALL leave COUNT unchanged and preserve FIFO order.
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated entries.
REQ-023 FLUSH==1 at an edge SHALL set COUNT=0, head=tail=0, and drop any same-cycle push and pop; FLUSH has priority over both.
REQ-024 A misaligned PUSH_pc with PUSH_valid==1 SHALL be rejected (no write) and SHALL set MISALIGN at that edge.
REQ-025 MISALIGN SHALL remain 1 until reset or FLUSH; FLUSH clears it unless the same cycle also offers a misaligned push.
REQ-026 COUNT SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-027 RESET==0 SHALL immediately, independent of CLK, force COUNT=0, head=tail=0, MISALIGN=0, POP_valid=0, POP_pc=0, POP_instr=0, PUSH_ready=1.
REQ-028 Storage array contents need not be reset; they SHALL NOT be observable on POP_* while empty.
REQ-029 Reset asserted mid-operation SHALL discard all entries; first push after deassertion SHALL land in entry 0.
REQ-030 No push or pop SHALL take effect on the first CLK edge at which RESET is 0.

Configuration
REQ-031 Macro FETCH_QUEUE_BYPASS_EN defined: when COUNT==0 and a valid aligned push is offered, POP_valid=1 combinationally with POP_pc=PUSH_pc, POP_instr=PUSH_instr; if POP_ready==1 that cycle the entry is consumed and not stored (COUNT stays 0).
REQ-032 Macro FETCH_QUEUE_BYPASS_EN undefined: no combinational path from PUSH_* to POP_*; minimum latency one edge per REQ-020.

Verification
REQ-033 RESET=0 then 1; push PC 0x0,0x4,0x8,0xC with POP_ready=0 -> COUNT=4, PUSH_ready=0; fifth push 0x10 rejected.
REQ-034 Full queue, POP_ready=1 for 4 cycles -> POP_pc 0x0,0x4,0x8,0xC in order, COUNT=0, POP_valid=0, POP_pc=0.
REQ-035 Continuous push/pop 10 entries PC 0x0..0x24 with COUNT=2 -> COUNT stays 2, order preserved across two pointer wraps.
REQ-036 COUNT=3, FLUSH=1 with simultaneous push 0x40 and pop -> COUNT=0 next cycle, 0x40 never appears on POP_pc.
REQ-037 Push PC 0x6 -> not stored, COUNT unchanged, MISALIGN=1 held until FLUSH pulse clears it.
REQ-038 Bypass build, empty queue, push PC 0x100 with POP_ready=1 -> POP_valid=1 and POP_pc=0x100 same cycle, COUNT stays 0; non-bypass build -> POP_valid=0 that cycle, 1 after edge.
